// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory among NUM_REQ requesters.
// Define MEM_ARB_TIMEOUT_EN to add the WAIT-state watchdog (drives req_err).
module mem_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int TIMEOUT    = 16
) (
   input  logic                          clk,
   input  logic                          res,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_wr_rd,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [WIDTH-1:0]              req_rdata,
   output logic [NUM_REQ-1:0]            req_err,
   output logic                          busy,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          mem_valid,
   output logic                          mem_wr_rd,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic [WIDTH-1:0]              mem_wdata,
   input  logic [WIDTH-1:0]              mem_rdata,
   input  logic                          mem_ready
);

   localparam int GW = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 2) begin : g_bad_params
      $error("mem_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t                 state_q, state_d;
   logic [GW-1:0]          last_grant_q, last_grant_d;
   logic [GW-1:0]          grant_id_q, grant_id_d;
   logic                   busy_q, busy_d;
   logic                   mem_valid_q, mem_valid_d;
   logic                   mem_wr_rd_q, mem_wr_rd_d;
   logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0]       mem_wdata_q, mem_wdata_d;
   logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;
   logic [WIDTH-1:0]       req_rdata_q, req_rdata_d;

   logic                   found;
   logic [GW-1:0]          win;
   logic                   win_wr;
   logic [ADDR_WIDTH-1:0]  win_addr;
   logic [WIDTH-1:0]       win_wdata;

   // Two passes: indices above last_grant first, then wrap to 0..last_grant.
   always_comb begin
      found     = 1'b0;
      win       = '0;
      win_wr    = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found && req_valid[j] && j > int'(last_grant_q)) begin
            found     = 1'b1;
            win       = GW'(j);
            win_wr    = req_wr_rd[j];
            win_addr  = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
            win_wdata = req_wdata[j*WIDTH +: WIDTH];
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found && req_valid[j] && j <= int'(last_grant_q)) begin
            found     = 1'b1;
            win       = GW'(j);
            win_wr    = req_wr_rd[j];
            win_addr  = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
            win_wdata = req_wdata[j*WIDTH +: WIDTH];
         end
      end
   end

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0]      tmo_cnt_q, tmo_cnt_d;
   logic [NUM_REQ-1:0] req_err_q, req_err_d;
   logic               tmo_hit;

   assign tmo_hit = (tmo_cnt_q == CW'(TIMEOUT - 1));

   // Cleared while in ISSUE so it starts at zero on WAIT entry.
   always_comb begin
      tmo_cnt_d = '0;
      if (state_q == WAIT) tmo_cnt_d = tmo_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         tmo_cnt_q <= '0;
         req_err_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         req_err_q <= req_err_d;
      end
   end

   assign req_err = req_err_q;
`else
   assign req_err = '0;
`endif

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      mem_valid_d  = 1'b0;
      mem_wr_rd_d  = mem_wr_rd_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      req_ready_d  = '0;
      req_rdata_d  = '0;
`ifdef MEM_ARB_TIMEOUT_EN
      req_err_d    = '0;
`endif
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d     = ISSUE;
               grant_id_d  = win;
               mem_valid_d = 1'b1;
               mem_wr_rd_d = win_wr;
               mem_addr_d  = win_addr;
               mem_wdata_d = win_wdata;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (mem_ready) begin
               state_d      = DONE;
               req_ready_d  = NUM_REQ'(1) << grant_id_q;
               req_rdata_d  = mem_wr_rd_q ? '0 : mem_rdata;
               last_grant_d = grant_id_q;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (tmo_hit) begin
               state_d      = DONE;
               req_ready_d  = NUM_REQ'(1) << grant_id_q;
               req_err_d    = NUM_REQ'(1) << grant_id_q;
               last_grant_d = grant_id_q;
            end
`endif
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q      <= IDLE;
         last_grant_q <= GW'(NUM_REQ - 1);
         grant_id_q   <= '0;
         busy_q       <= 1'b0;
         mem_valid_q  <= 1'b0;
         mem_wr_rd_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         req_ready_q  <= '0;
         req_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
         busy_q       <= busy_d;
         mem_valid_q  <= mem_valid_d;
         mem_wr_rd_q  <= mem_wr_rd_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         req_ready_q  <= req_ready_d;
         req_rdata_q  <= req_rdata_d;
      end
   end

   assign req_ready = req_ready_q;
   assign req_rdata = req_rdata_q;
   assign busy      = busy_q;
   assign grant_id  = grant_id_q;
   assign mem_valid = mem_valid_q;
   assign mem_wr_rd = mem_wr_rd_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random requesters, memory model, round-robin reference.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int N     = 4;
   localparam int W     = 8;
   localparam int DEPTH = 256;
   localparam int AW    = 8;
   localparam int TMO   = 16;
   localparam int GW    = 2;

   logic              clk = 1'b0;
   logic              res;
   logic [N-1:0]      req_valid, req_wr_rd, req_ready, req_err;
   logic [N*AW-1:0]   req_addr;
   logic [N*W-1:0]    req_wdata;
   logic [W-1:0]      req_rdata;
   logic              busy;
   logic [GW-1:0]     grant_id;
   logic              mem_valid, mem_wr_rd;
   logic [AW-1:0]     mem_addr;
   logic [W-1:0]      mem_wdata;
   logic [W-1:0]      mem_rdata = '0;
   logic              mem_ready = 1'b0;

   mem_arbiter #(
      .NUM_REQ(N), .WIDTH(W), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .res(res),
      .req_valid(req_valid), .req_wr_rd(req_wr_rd),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .req_rdata(req_rdata), .req_err(req_err),
      .busy(busy), .grant_id(grant_id),
      .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   // Registered single-port memory; stall suppresses the acknowledge.
   logic [W-1:0] mem [DEPTH];
   logic         stall;
   logic         mem_clr;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         mem_ready <= 1'b0;
      end else begin
         mem_ready <= mem_valid && !stall;
         if (mem_valid) begin
            if (mem_wr_rd) mem[mem_addr] <= mem_wdata;
            else           mem_rdata     <= mem[mem_addr];
         end
      end
   end

   typedef struct {
      int           id;
      logic         wr;
      logic [AW-1:0] addr;
      logic [W-1:0] wdata;
      int           cyc;
   } iss_t;

   typedef struct {
      int           id;
      logic [W-1:0] rdata;
      logic         err;
      int           cyc;
   } done_t;

   iss_t  iss_q[$];
   done_t done_q[$];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: transfers are serialized; each one takes a fixed number of
   // cycles, and the next pick starts from the previous winner plus one.
   logic [W-1:0] ref_mem [DEPTH];
   int cyc = 0;
   int m_last, m_next_arb, m_busy_lo, m_busy_hi;

   initial begin
      int w, lat, c;
      iss_t  e;
      done_t d;
      m_last = N - 1; m_next_arb = 0; m_busy_lo = 1; m_busy_hi = 0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      forever begin
         @(posedge clk);
         cyc++;
         if (!res) begin
            m_last = N - 1; m_next_arb = 0; m_busy_lo = 1; m_busy_hi = 0;
            iss_q.delete();
            done_q.delete();
         end else if (cyc >= m_next_arb && req_valid != '0) begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
               c = (m_last + k) % N;
               if (w < 0 && req_valid[c]) w = c;
            end
            e.id = w; e.cyc = cyc;
            e.wr = req_wr_rd[w];
            e.addr = req_addr[w*AW +: AW];
            e.wdata = req_wdata[w*W +: W];
            d.id = w;
            d.err = 1'b0;
            d.rdata = e.wr ? '0 : ref_mem[e.addr];
            if (e.wr) ref_mem[e.addr] = e.wdata;
            lat = 2;
            if (stall) begin
`ifdef MEM_ARB_TIMEOUT_EN
               lat = TMO + 1;
               d.err = 1'b1;
               d.rdata = '0;
`else
               lat = 1000000;
`endif
            end
            d.cyc = cyc + lat;
            iss_q.push_back(e);
            done_q.push_back(d);
            m_last = w;
            m_busy_lo = cyc;
            m_busy_hi = cyc + lat;
            m_next_arb = cyc + lat + 2;
         end
      end
   end

   int   served_cnt[N];
   int   issued_cnt[N];
   logic prev_mv = 1'b0;

   initial begin
      iss_t  e;
      done_t d;
      for (int i = 0; i < N; i++) begin served_cnt[i] = 0; issued_cnt[i] = 0; end
      forever begin
         @(negedge clk);
         if (!res) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_req_rdata", req_rdata, 0);
            chk("rst_req_err", req_err, 0);
            chk("rst_busy", busy, 0);
            chk("rst_grant_id", grant_id, 0);
            chk("rst_mem_valid", mem_valid, 0);
            prev_mv = 1'b0;
         end else begin
            chk("busy", busy, (cyc >= m_busy_lo && cyc <= m_busy_hi) ? 1 : 0);
            if (mem_valid) begin
               chk("mem_valid_back_to_back", prev_mv, 0);
               if (iss_q.size() == 0) chk("mem_valid_unexpected", mem_valid, 0);
               else begin
                  e = iss_q.pop_front();
                  chk("issue_cycle", cyc, e.cyc);
                  chk("issue_grant_id", grant_id, e.id);
                  chk("mem_wr_rd", mem_wr_rd, e.wr);
                  chk("mem_addr", mem_addr, e.addr);
                  if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
                  issued_cnt[e.id]++;
               end
            end
            prev_mv = mem_valid;
            if (req_ready != '0) begin
               if (done_q.size() == 0) chk("req_ready_unexpected", req_ready, 0);
               else begin
                  d = done_q.pop_front();
                  chk("ready_cycle", cyc, d.cyc);
                  chk("req_ready_onehot", req_ready, 1 << d.id);
                  chk("req_rdata", req_rdata, d.rdata);
                  chk("req_err", req_err, d.err ? (1 << d.id) : 0);
                  chk("done_grant_id", grant_id, d.id);
                  served_cnt[d.id]++;
               end
            end else begin
               chk("rdata_quiet", req_rdata, 0);
               chk("err_quiet", req_err, 0);
            end
         end
      end
   end

   int   served_seen[N];
   int   issued_seen[N];
   logic scramble;

   task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                          input logic [W-1:0] dt);
      req_valid[i] = 1'b1;
      req_wr_rd[i] = wr;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*W +: W] = dt;
   endtask

   // Requesters hold until their completion pulse, then drop.
   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (served_cnt[i] != served_seen[i]) begin
            served_seen[i] = served_cnt[i];
            req_valid[i] = 1'b0;
         end
         if (issued_cnt[i] != issued_seen[i]) begin
            issued_seen[i] = issued_cnt[i];
            if (scramble && req_valid[i]) begin
               req_wr_rd[i] = 1'($urandom_range(0, 1));
               req_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
               req_wdata[i*W +: W] = W'($urandom);
            end
         end
      end
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (n < budget && (req_valid != '0 || iss_q.size() != 0 || done_q.size() != 0)) begin
         step();
         n++;
      end
      if (n >= budget) begin
         chk("drain_req_valid", req_valid, 0);
         chk("drain_issue_q", iss_q.size(), 0);
         chk("drain_done_q", done_q.size(), 0);
      end
   endtask

   task automatic wait_served(input int i, input int budget);
      int n, s0;
      n = 0;
      s0 = served_seen[i];
      while (n < budget && served_seen[i] == s0) begin
         step();
         n++;
      end
      if (n >= budget) chk("served_timeout", served_seen[i], s0 + 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int s2;
      res = 1'b1;
      req_valid = '0; req_wr_rd = '0; req_addr = '0; req_wdata = '0;
      stall = 1'b0; mem_clr = 1'b1; scramble = 1'b0;
      for (int i = 0; i < N; i++) begin served_seen[i] = 0; issued_seen[i] = 0; end
      #1 res = 1'b0;
      repeat (3) step();
      mem_clr = 1'b0;
      res = 1'b1;

      // All four hold reads from reset; 0 comes back once more.
      for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), '0);
      wait_served(0, 40);
      set_req(0, 1'b0, 8'h04, '0);
      wait_idle(100);

      // Requester 1 writes then reads back.
      set_req(1, 1'b1, 8'h10, 8'hA5);
      wait_idle(40);
      set_req(1, 1'b0, 8'h10, '0);
      wait_idle(40);

      // After a grant to 2: 3 beats 2, and 0 joins once 3 is served.
      set_req(2, 1'b0, 8'h20, '0);
      wait_idle(40);
      set_req(2, 1'b1, 8'h21, 8'h3C);
      set_req(3, 1'b1, 8'h22, 8'h5A);
      wait_served(3, 40);
      set_req(0, 1'b0, 8'h21, '0);
      wait_idle(60);

      // Requester 1 withdraws while 3 is being served.
      set_req(3, 1'b0, 8'h22, '0);
      step();
      set_req(1, 1'b1, 8'h22, 8'hEE);
      step();
      req_valid[1] = 1'b0;
      wait_idle(40);

      // Random traffic with fields changed after each grant.
      scramble = 1'b1;
      for (int t = 0; t < 300; t++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0)
               set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), W'($urandom));
         end
         step();
      end
      scramble = 1'b0;
      wait_idle(200);

      // Reset pulled in WAIT; afterwards requester 0 must win first.
      stall = 1'b1;
      set_req(1, 1'b0, 8'h03, '0);
      set_req(2, 1'b0, 8'h05, '0);
      repeat (4) step();
      res = 1'b0;
      repeat (2) step();
      set_req(0, 1'b0, 8'h10, '0);
      stall = 1'b0;
      res = 1'b1;
      wait_idle(80);

      // Memory never acknowledges.
      stall = 1'b1;
      set_req(2, 1'b0, 8'h10, '0);
`ifdef MEM_ARB_TIMEOUT_EN
      wait_served(2, 100);
      stall = 1'b0;
      wait_idle(40);
`else
      s2 = served_cnt[2];
      repeat (3 * TMO) step();
      chk("stuck_busy", busy, 1);
      chk("stuck_no_ready", served_cnt[2], s2);
      res = 1'b0;
      repeat (2) step();
      stall = 1'b0;
      res = 1'b1;
      wait_idle(40);
`endif

      chk("final_queues_empty", iss_q.size() + done_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
